// File: rtl/riscv_clint_timer.sv
// Machine timer + software-interrupt unit: 64-bit mtime with prescaler, NUM_HARTS mtimecmp comparators, msip bits.
// Bus latency fixed at one cycle, no backpressure (one request per cycle accepted); mtip registered one cycle behind state.
module riscv_clint_timer #(
    parameter int          XLEN       = 32,
    parameter int          NUM_HARTS  = 1,
    parameter int          PRESCALE_W = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_8000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_valid,
    input  logic                 mem_we,
    input  logic [31:0]          mem_addr,
    input  logic [XLEN-1:0]      mem_wdata,
    output logic [XLEN-1:0]      mem_rdata,
    output logic                 mem_ready,
    output logic                 mem_err,
    output logic [NUM_HARTS-1:0] mtip,
    output logic [NUM_HARTS-1:0] msip
);

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [63:0]           mtime_q, mtime_d;
    logic [31:0]           mtime_hi_shadow_q, mtime_hi_shadow_d;
    logic [63:0]           mtimecmp_q [NUM_HARTS];
    logic [63:0]           mtimecmp_d [NUM_HARTS];
    logic [NUM_HARTS-1:0]  msip_q, msip_d;
    logic [NUM_HARTS-1:0]  mtip_q, mtip_d;
    logic                  mem_ready_q, mem_ready_d;
    logic                  mem_err_q, mem_err_d;
    logic [XLEN-1:0]       mem_rdata_q, mem_rdata_d;

    logic                  req, wr, rd, hit, tick;
    logic [11:0]           off;
    logic                  sel_presc, sel_tlo, sel_thi;
    logic [NUM_HARTS-1:0]  sel_clo, sel_chi, sel_msip;
    logic [31:0]           rd_val;

    assign req  = mem_valid && (mem_addr[31:12] == BASE_ADDR[31:12]);
    assign wr   = req && mem_we;
    assign rd   = req && !mem_we;
    assign off  = mem_addr[11:0];
    assign tick = (presc_cnt_q == presc_q);

    always_comb begin
        sel_presc = (off == 12'h000);
        sel_tlo   = (off == 12'h004);
        sel_thi   = (off == 12'h008);
        sel_clo   = '0;
        sel_chi   = '0;
        sel_msip  = '0;
        for (int k = 0; k < NUM_HARTS; k++) begin
            sel_clo[k]  = (off == 12'(32'h00C + 8 * k));
            sel_chi[k]  = (off == 12'(32'h010 + 8 * k));
            sel_msip[k] = (off == 12'(32'h100 + 4 * k));
        end
        hit = sel_presc || sel_tlo || sel_thi || (|sel_clo) || (|sel_chi) || (|sel_msip);
    end

    // Undecoded offsets fall through to zero.
    always_comb begin
        rd_val = '0;
        if (sel_presc) rd_val = 32'(presc_q);
        if (sel_tlo)   rd_val = mtime_q[31:0];
        if (sel_thi)   rd_val = mtime_hi_shadow_q;
        for (int k = 0; k < NUM_HARTS; k++) begin
            if (sel_clo[k])  rd_val = mtimecmp_q[k][31:0];
            if (sel_chi[k])  rd_val = mtimecmp_q[k][63:32];
            if (sel_msip[k]) rd_val = 32'(msip_q[k]);
        end
    end

    always_comb begin
        presc_d           = presc_q;
        presc_cnt_d       = tick ? '0 : presc_cnt_q + 1'b1;
        mtime_d           = tick ? mtime_q + 64'd1 : mtime_q;
        mtime_hi_shadow_d = mtime_hi_shadow_q;
        mtimecmp_d        = mtimecmp_q;
        msip_d            = msip_q;

        if (wr && sel_presc) begin
            presc_d     = mem_wdata[PRESCALE_W-1:0];
            presc_cnt_d = '0;
        end
        // A half-word write wins over the tick and never carries into the other half.
        if (wr && sel_tlo) mtime_d = {mtime_q[63:32], mem_wdata};
        if (wr && sel_thi) mtime_d = {mem_wdata, mtime_q[31:0]};
        if (rd && sel_tlo) mtime_hi_shadow_d = mtime_q[63:32];

        for (int k = 0; k < NUM_HARTS; k++) begin
            if (wr && sel_clo[k])  mtimecmp_d[k] = {mtimecmp_q[k][63:32], mem_wdata};
            if (wr && sel_chi[k])  mtimecmp_d[k] = {mem_wdata, mtimecmp_q[k][31:0]};
            if (wr && sel_msip[k]) msip_d[k]     = mem_wdata[0];
        end
    end

    always_comb begin
        mtip_d = '0;
        for (int k = 0; k < NUM_HARTS; k++) begin
            mtip_d[k] = (mtime_q >= mtimecmp_q[k]);
        end
        mem_ready_d = req;
        mem_err_d   = req && !hit;
        mem_rdata_d = rd ? rd_val : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q           <= '0;
            presc_cnt_q       <= '0;
            mtime_q           <= '0;
            mtime_hi_shadow_q <= '0;
            for (int k = 0; k < NUM_HARTS; k++) begin
                mtimecmp_q[k] <= '1;
            end
            msip_q            <= '0;
            mtip_q            <= '0;
            mem_ready_q       <= 1'b0;
            mem_err_q         <= 1'b0;
            mem_rdata_q       <= '0;
        end else begin
            presc_q           <= presc_d;
            presc_cnt_q       <= presc_cnt_d;
            mtime_q           <= mtime_d;
            mtime_hi_shadow_q <= mtime_hi_shadow_d;
            mtimecmp_q        <= mtimecmp_d;
            msip_q            <= msip_d;
            mtip_q            <= mtip_d;
            mem_ready_q       <= mem_ready_d;
            mem_err_q         <= mem_err_d;
            mem_rdata_q       <= mem_rdata_d;
        end
    end

    assign mem_ready = mem_ready_q;
    assign mem_err   = mem_err_q;
    assign mem_rdata = mem_rdata_q;
    assign mtip      = mtip_q;
    assign msip      = msip_q;

endmodule

// File: tb/tb_riscv_clint_timer.sv
// Directed bench for riscv_clint_timer with a cycle-level reference model and per-cycle output comparison.
module tb_riscv_clint_timer;
    localparam int          NH   = 2;
    localparam logic [31:0] BASE = 32'h0000_8000;

    localparam logic [31:0] A_PRESC = BASE + 32'h000;
    localparam logic [31:0] A_TLO   = BASE + 32'h004;
    localparam logic [31:0] A_THI   = BASE + 32'h008;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            mem_valid = 1'b0;
    logic            mem_we = 1'b0;
    logic [31:0]     mem_addr = '0;
    logic [31:0]     mem_wdata = '0;
    logic [31:0]     mem_rdata;
    logic            mem_ready, mem_err;
    logic [NH-1:0]   mtip, msip;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    riscv_clint_timer #(
        .XLEN(32), .NUM_HARTS(NH), .PRESCALE_W(16), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .mem_err(mem_err), .mtip(mtip), .msip(msip)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] m_time, m_cmp [NH];
    logic [15:0] m_presc, m_cnt;
    logic [31:0] m_shadow;
    logic [NH-1:0] m_msip, e_mtip;
    logic        e_rdy, e_err;
    logic [31:0] e_rdata;
    bit          model_ok = 0;
    logic [63:0] n_time;
    logic [15:0] n_cnt;
    int          off, hk;
    bit          tick, hit;

    always @(posedge clk) begin
        if (rst) begin
            m_time = 0; m_presc = 0; m_cnt = 0; m_shadow = 0; m_msip = 0;
            for (int k = 0; k < NH; k++) m_cmp[k] = 64'hFFFF_FFFF_FFFF_FFFF;
            e_mtip = 0; e_rdy = 0; e_err = 0; e_rdata = 0;
            model_ok = 1;
        end else if (model_ok) begin
            for (int k = 0; k < NH; k++) e_mtip[k] = (m_time >= m_cmp[k]);
            tick   = (m_cnt == m_presc);
            n_time = tick ? m_time + 1 : m_time;
            n_cnt  = tick ? 16'd0 : m_cnt + 16'd1;
            e_rdy = 0; e_err = 0; e_rdata = 0;
            if (mem_valid && mem_addr[31:12] == BASE[31:12]) begin
                e_rdy = 1;
                hit = 1;
                off = int'(mem_addr[11:0]);
                if (off == 0) begin
                    if (mem_we) begin m_presc = mem_wdata[15:0]; n_cnt = 0; end
                    else e_rdata = {16'h0, m_presc};
                end else if (off == 4) begin
                    if (mem_we) n_time = {m_time[63:32], mem_wdata};
                    else begin e_rdata = m_time[31:0]; m_shadow = m_time[63:32]; end
                end else if (off == 8) begin
                    if (mem_we) n_time = {mem_wdata, m_time[31:0]};
                    else e_rdata = m_shadow;
                end else if (off >= 12 && off < 12 + 8 * NH && off % 4 == 0) begin
                    hk = (off - 12) / 8;
                    if ((off - 12) % 8 == 0) begin
                        if (mem_we) m_cmp[hk][31:0] = mem_wdata;
                        else e_rdata = m_cmp[hk][31:0];
                    end else begin
                        if (mem_we) m_cmp[hk][63:32] = mem_wdata;
                        else e_rdata = m_cmp[hk][63:32];
                    end
                end else if (off >= 256 && off < 256 + 4 * NH && off % 4 == 0) begin
                    hk = (off - 256) / 4;
                    if (mem_we) m_msip[hk] = mem_wdata[0];
                    else e_rdata = {31'h0, m_msip[hk]};
                end else begin
                    hit = 0;
                end
                e_err = !hit;
            end
            m_time = n_time;
            m_cnt  = n_cnt;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("mem_ready", mem_ready, e_rdy);
            check("mem_rdata", mem_rdata, e_rdata);
            check("mem_err", mem_err, e_err);
            check("mtip", mtip, e_mtip);
            check("msip", msip, m_msip);
        end
    end

    // ---------------- stimulus ----------------
    task automatic req(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rdat, output logic er, output logic rdy);
        mem_valid = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wd;
        @(negedge clk);
        rdat = mem_rdata; er = mem_err; rdy = mem_ready;
        mem_valid = 1'b0; mem_we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] d; logic e, r;
        req(1'b1, addr, wd, d, e, r);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] d);
        logic e, r;
        req(1'b0, addr, 32'h0, d, e, r);
    endtask

    function automatic logic [31:0] a_clo(input int k); return BASE + 32'(12 + 8 * k); endfunction
    function automatic logic [31:0] a_chi(input int k); return BASE + 32'(16 + 8 * k); endfunction
    function automatic logic [31:0] a_msip(input int k); return BASE + 32'(256 + 4 * k); endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d0, d1, d2, d3;
        logic        e0, e1, e2, r0;
        int          first;
        bit          m0_seen;

        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: reset state and free-running count
        check("reset mtip", mtip, 0);
        check("reset msip", msip, 0);
        rd(A_PRESC, d0);  check("prescale reset", d0, 0);
        rd(A_TLO, d0);
        rd(A_TLO, d1);    check("mtime step", d1 - d0, 1);
        rd(A_THI, d0);    check("mtime hi reset", d0, 0);
        rd(a_clo(0), d0); check("cmp0 lo reset", d0, 32'hFFFF_FFFF);
        rd(a_chi(1), d0); check("cmp1 hi reset", d0, 32'hFFFF_FFFF);

        // 2: prescale 3 gives 10 ticks in 40 cycles
        wr(A_PRESC, 32'd3);
        rd(A_PRESC, d0);  check("prescale readback", d0, 3);
        rd(A_TLO, d0);
        repeat (39) @(negedge clk);
        rd(A_TLO, d1);    check("prescale delta", d1 - d0, 10);

        // 3: comparator 1 crossing and withdrawal
        wr(A_PRESC, 32'd0);
        wr(a_clo(1), 32'd100);
        wr(a_chi(1), 32'd0);
        wr(A_THI, 32'd0);
        wr(A_TLO, 32'd50);
        first = 0; m0_seen = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (mtip[1] && first == 0) first = k;
            if (mtip[0]) m0_seen = 1;
        end
        check("mtip1 rise cycle", first, 51);
        check("mtip0 quiet", m0_seen, 0);
        wr(a_chi(1), 32'd1);
        check("mtip1 still set", mtip[1], 1);
        @(negedge clk);
        check("mtip1 cleared", mtip[1], 0);

        // 4: coherent 64-bit read across the low-word wrap
        wr(A_THI, 32'd0);
        wr(A_TLO, 32'hFFFF_FFFE);
        @(negedge clk);
        rd(A_TLO, d0); rd(A_THI, d1);
        check("wrap pair 1", {d1, d0}, 64'h0000_0000_FFFF_FFFF);
        rd(A_TLO, d0); rd(A_THI, d1);
        check("wrap pair 2", {d1, d0}, 64'h0000_0001_0000_0001);

        // 5: msip and error decode, back to back
        wr(a_msip(0), 32'd1);
        check("msip0 set", msip[0], 1);
        req(1'b0, BASE + 32'h100, 0, d0, e0, r0);
        req(1'b0, BASE + 32'h200, 0, d1, e1, r0);
        req(1'b0, BASE + 32'h01C, 0, d2, e2, r0);
        check("rdata seq", {d0, d1, d2}, {32'd1, 32'd0, 32'd0});
        check("err seq", {e0, e1, e2}, 3'b011);
        wr(BASE + 32'h01C, 32'h1234);
        req(1'b0, 32'h0000_9004, 0, d3, e0, r0);
        check("outside window ready", r0, 0);
        rd(a_msip(1), d3); check("msip1 read", d3, 0);

        // 6: reset mid-count with mtip[0] high and a read in flight
        wr(a_clo(0), 32'd0);
        wr(a_chi(0), 32'd0);
        @(negedge clk);
        check("mtip0 before reset", mtip[0], 1);
        mem_valid = 1'b1; mem_we = 1'b0; mem_addr = A_TLO; rst = 1'b1;
        @(negedge clk);
        check("mtip after reset", mtip, 0);
        check("ready after reset", mem_ready, 0);
        rst = 1'b0; mem_valid = 1'b0;
        rd(A_TLO, d0); check("mtime restart 0", d0, 0);
        rd(A_TLO, d0); check("mtime restart 1", d0, 1);
        rd(a_clo(0), d0); check("cmp0 lo re-reset", d0, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
